// File: rtl/gate_clock_ctrl.sv
// Clock-gate controller: drives the registered enable of a latch-based gating cell.
// A req/ack handshake wakes the clock, busy keeps it running, and an idle hold-off delays shutdown.
module gate_clock_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_HOLD   = 8,
  parameter int CNTW        = 4,
  parameter int MONW        = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enableGate,
  input  logic            req,
  input  logic            busy,
  output logic            gate,
  output logic            ack,
  output logic [1:0]      state,
  output logic [MONW-1:0] wakeCount
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } gateState_t;

  localparam logic [CNTW-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CNTW'(WAKE_CYCLES - 1) : '0;
  localparam logic [CNTW-1:0] HOLD_LOAD = (IDLE_HOLD > 0)   ? CNTW'(IDLE_HOLD - 1)   : '0;
  localparam bit              WAKE_SKIP = (WAKE_CYCLES == 0);
  localparam bit              HOLD_SKIP = (IDLE_HOLD == 0);

  gateState_t      stateQ;
  logic [CNTW-1:0] cnt;
  logic            act;

  assign act   = req | busy;
  assign state = stateQ;

  // gate and ack are dedicated flops rather than a decode of stateQ, so a
  // multi-bit state change (e.g. WAKE->ON) can never glitch the gating cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses <= so every register sees pre-edge values.
      stateQ    <= OFF;
      gate      <= 1'b0;
      ack       <= 1'b0;
      cnt       <= '0;
      wakeCount <= '0;
    end else begin
      case (stateQ)
        OFF: begin
          // Any exit from OFF is a wake event, including a forced-on.
          if (!enableGate || act) begin
            if (wakeCount != '1) wakeCount <= wakeCount + 1'b1;
            gate <= 1'b1;
            if (!enableGate || WAKE_SKIP) begin
              stateQ <= ON;
              ack    <= 1'b1;
            end else begin
              stateQ <= WAKE;
              cnt    <= WAKE_LOAD;
            end
          end
        end

        WAKE: begin
          // A dropped request does not abort the wake; ON handles the idle path.
          if (!enableGate || cnt == '0) begin
            stateQ <= ON;
            ack    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ON: begin
          if (enableGate && !act) begin
            if (HOLD_SKIP) begin
              stateQ <= OFF;
              gate   <= 1'b0;
              ack    <= 1'b0;
            end else begin
              stateQ <= HOLD;
              cnt    <= HOLD_LOAD;
            end
          end
        end

        HOLD: begin
          if (!enableGate || act) begin
            stateQ <= ON;
          end else if (cnt == '0) begin
            stateQ <= OFF;
            gate   <= 1'b0;
            ack    <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          stateQ <= OFF;
          gate   <= 1'b0;
          ack    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_clock_ctrl.sv
// Directed bench for gate_clock_ctrl: default build plus a WAKE_CYCLES=0 / IDLE_HOLD=0 / MONW=2 build.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_gate_clock_ctrl;

  logic       clk = 1'b0;
  logic       resetA, enA, reqA, busyA, gateA, ackA;
  logic [1:0] stateA;
  logic [7:0] wcA;
  logic       resetB, enB, reqB, busyB, gateB, ackB;
  logic [1:0] stateB;
  logic [1:0] wcB;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  gate_clock_ctrl #(.WAKE_CYCLES(2), .IDLE_HOLD(8), .CNTW(4), .MONW(8)) dutA (
    .clk(clk), .reset(resetA), .enableGate(enA), .req(reqA), .busy(busyA),
    .gate(gateA), .ack(ackA), .state(stateA), .wakeCount(wcA)
  );

  gate_clock_ctrl #(.WAKE_CYCLES(0), .IDLE_HOLD(0), .CNTW(4), .MONW(2)) dutB (
    .clk(clk), .reset(resetB), .enableGate(enB), .req(reqB), .busy(busyB),
    .gate(gateB), .ack(ackB), .state(stateB), .wakeCount(wcB)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {gate, ack, state} so one comparison covers all three outputs.
  task automatic checkA(input string tag, input logic g, input logic a, input logic [1:0] s);
    check(tag, {28'd0, gateA, ackA, stateA}, {28'd0, g, a, s});
  endtask

  task automatic checkB(input string tag, input logic g, input logic a, input logic [1:0] s);
    check(tag, {28'd0, gateB, ackB, stateB}, {28'd0, g, a, s});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetA = 1'b1; enA = 1'b1; reqA = 1'b0; busyA = 1'b0;
    resetB = 1'b1; enB = 1'b1; reqB = 1'b0; busyB = 1'b0;
    step(2);
    checkA("reset_outputs", 1'b0, 1'b0, 2'd0);
    check("reset_wakeCount", wcA, 0);
    resetA = 1'b0;
    step(3);
    checkA("idle_stays_off", 1'b0, 1'b0, 2'd0);

    // Wake latency: gate the edge after req, ack two edges later.
    reqA = 1'b1;
    step(1); checkA("wake_first", 1'b1, 1'b0, 2'd1);
    check("wake_count_1", wcA, 1);
    step(1); checkA("wake_second", 1'b1, 1'b0, 2'd1);
    step(1); checkA("wake_to_on", 1'b1, 1'b1, 2'd2);
    step(4); checkA("on_steady", 1'b1, 1'b1, 2'd2);

    // Shutdown: eight cycles of HOLD, then OFF.
    reqA = 1'b0;
    step(1); checkA("hold_enter", 1'b1, 1'b1, 2'd3);
    step(7); checkA("hold_last", 1'b1, 1'b1, 2'd3);
    step(1); checkA("hold_to_off", 1'b0, 1'b0, 2'd0);
    check("wake_count_still_1", wcA, 1);

    // busy in the third HOLD cycle revives ON without a gate drop.
    reqA = 1'b1;
    step(3); checkA("second_wake_on", 1'b1, 1'b1, 2'd2);
    check("wake_count_2", wcA, 2);
    reqA = 1'b0;
    step(3); checkA("hold_third", 1'b1, 1'b1, 2'd3);
    busyA = 1'b1;
    step(1); checkA("busy_back_on", 1'b1, 1'b1, 2'd2);
    check("busy_no_wake_count", wcA, 2);

    // Activity on the expiry cycle of HOLD beats the shutdown.
    busyA = 1'b0;
    step(8); checkA("hold_expiry_cycle", 1'b1, 1'b1, 2'd3);
    busyA = 1'b1;
    step(1); checkA("act_beats_expiry", 1'b1, 1'b1, 2'd2);
    busyA = 1'b0;
    step(9); checkA("expiry_off", 1'b0, 1'b0, 2'd0);

    // Disabled gating forces the clock on and suppresses HOLD.
    enA = 1'b0;
    step(1); checkA("force_on_from_off", 1'b1, 1'b1, 2'd2);
    reqA = 1'b1;
    step(2);
    reqA = 1'b0;
    step(2); checkA("disabled_no_hold", 1'b1, 1'b1, 2'd2);
    enA = 1'b1;
    step(8); checkA("reenable_hold", 1'b1, 1'b1, 2'd3);
    step(1); checkA("reenable_off", 1'b0, 1'b0, 2'd0);

    // Disable during WAKE and during HOLD jumps straight to ON.
    reqA = 1'b1;
    step(1); checkA("wake_before_disable", 1'b1, 1'b0, 2'd1);
    enA = 1'b0;
    step(1); checkA("disable_in_wake", 1'b1, 1'b1, 2'd2);
    enA = 1'b1; reqA = 1'b0;
    step(1); checkA("hold_before_disable", 1'b1, 1'b1, 2'd3);
    enA = 1'b0;
    step(1); checkA("disable_in_hold", 1'b1, 1'b1, 2'd2);
    enA = 1'b1;
    step(9); checkA("disable_seq_off", 1'b0, 1'b0, 2'd0);

    // One-cycle req pulse still completes the whole wake.
    reqA = 1'b1;
    step(1); reqA = 1'b0;
    checkA("pulse_wake1", 1'b1, 1'b0, 2'd1);
    step(1); checkA("pulse_wake2", 1'b1, 1'b0, 2'd1);
    step(1); checkA("pulse_on", 1'b1, 1'b1, 2'd2);
    step(1); checkA("pulse_hold", 1'b1, 1'b1, 2'd3);
    step(7); checkA("pulse_hold_last", 1'b1, 1'b1, 2'd3);
    step(1); checkA("pulse_off", 1'b0, 1'b0, 2'd0);

    // Reset in WAKE and in ON drops everything on the next edge.
    reqA = 1'b1;
    step(1); checkA("pre_reset_wake", 1'b1, 1'b0, 2'd1);
    resetA = 1'b1;
    step(1); checkA("reset_in_wake", 1'b0, 1'b0, 2'd0);
    check("reset_in_wake_count", wcA, 0);
    resetA = 1'b0;
    step(1); checkA("post_reset_wake", 1'b1, 1'b0, 2'd1);
    step(2); checkA("post_reset_on", 1'b1, 1'b1, 2'd2);
    check("post_reset_count", wcA, 1);
    resetA = 1'b1;
    step(1); checkA("reset_in_on", 1'b0, 1'b0, 2'd0);
    check("reset_in_on_count", wcA, 0);
    resetA = 1'b0; reqA = 1'b0;
    step(1); checkA("after_reset_idle", 1'b0, 1'b0, 2'd0);

    // Zero-latency build: ack with gate, drop one edge after act low, 2-bit saturation.
    resetB = 1'b0;
    step(1); checkB("b_reset_off", 1'b0, 1'b0, 2'd0);
    check("b_reset_count", {30'd0, wcB}, 0);
    reqB = 1'b1;
    step(1); checkB("b_direct_on", 1'b1, 1'b1, 2'd2);
    check("b_count_1", {30'd0, wcB}, 1);
    reqB = 1'b0;
    step(1); checkB("b_direct_off", 1'b0, 1'b0, 2'd0);
    busyB = 1'b1;
    step(1); checkB("b_busy_on", 1'b1, 1'b1, 2'd2);
    check("b_count_2", {30'd0, wcB}, 2);
    busyB = 1'b0;
    step(1);
    reqB = 1'b1;
    step(1); check("b_count_3", {30'd0, wcB}, 3);
    reqB = 1'b0;
    step(1);
    reqB = 1'b1;
    step(1); check("b_count_saturated", {30'd0, wcB}, 3);
    reqB = 1'b0;
    step(1);
    reqB = 1'b1;
    step(1); check("b_count_no_wrap", {30'd0, wcB}, 3);
    reqB = 1'b0;
    step(1); checkB("b_final_off", 1'b0, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
